// File: rtl/sc_result_collector.sv
// Result collector for the SC FIR datapath: decodes four lane one-counts to bipolar values,
// sums them and queues the sums in a small FIFO. Define SC_AVG_EN to emit the lane mean (S>>>2).
module sc_result_collector #(
    parameter int N     = 12,
    parameter int LANES = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [(N+1)*LANES-1:0]     in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [N+3:0]        out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int CW = N + 1;
    localparam int BW = N + 2;
    localparam int SW = N + 4;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    function automatic logic signed [BW-1:0] decode(input logic [CW-1:0] c);
        logic [CW-1:0]       cl;
        logic signed [BW:0]  t;
        cl = (c > CW'(1 << N)) ? CW'(1 << N) : c;
        t  = $signed({1'b0, cl, 1'b0}) - $signed((BW+1)'(1 << N));
        return BW'(t);
    endfunction

    function automatic logic signed [SW-1:0] scale(input logic signed [SW-1:0] s);
`ifdef SC_AVG_EN
        return s >>> 2;
`else
        return s;
`endif
    endfunction

    // Stage 1: clamp and bipolar decode per lane
    logic signed [BW-1:0] lane_p0 [LANES];
    logic                 vld_p0;

    always_ff @(posedge clock) begin
        if (in_valid) begin
            for (int i = 0; i < LANES; i++)
                lane_p0[i] <= decode(in_data[CW*i +: CW]);
        end
    end

    // Stage 2: lane sum (optionally averaged)
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] sum_p1;
    logic                 vld_p1;

    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++)
            sum = sum + SW'(lane_p0[i]);
    end

    always_ff @(posedge clock) begin
        if (vld_p0)
            sum_p1 <= scale(sum);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= in_valid;
            vld_p1 <= vld_p0;
        end
    end

    // FIFO: out_data is a registered copy of the head entry
    logic signed [SW-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 pop;
    logic                 push;

    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    assign push      = vld_p1 && ((level != LW'(DEPTH)) || pop);

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= sum_p1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            out_data <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
            if (vld_p1 && !push)
                overflow <= 1'b1;
            // Next head: following entry on a pop, else the incoming word when it lands in an empty slot
            if (pop) begin
                if (level > LW'(1))
                    out_data <= mem[rd_ptr + 1'b1];
                else if (push)
                    out_data <= sum_p1;
            end else if (push && level == '0) begin
                out_data <= sum_p1;
            end
        end
    end

endmodule

// File: tb/tb_sc_result_collector.sv
// Directed bench for sc_result_collector; expectations follow SC_AVG_EN when defined.
module tb_sc_result_collector;

    localparam int N     = 12;
    localparam int LANES = 4;
    localparam int DEPTH = 4;

    logic                       clock = 1'b0;
    logic                       reset_n = 1'b0;
    logic                       in_valid = 1'b0;
    logic [(N+1)*LANES-1:0]     in_data = '0;
    logic                       out_valid;
    logic                       out_ready = 1'b0;
    logic signed [N+3:0]        out_data;
    logic [$clog2(DEPTH):0]     level;
    logic                       overflow;

    int n_cmp = 0;
    int n_bad = 0;

    sc_result_collector #(.N(N), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .level(level),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic chk_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [(N+1)*LANES-1:0] pack(input int c0, input int c1, input int c2, input int c3);
        return {13'(c3), 13'(c2), 13'(c1), 13'(c0)};
    endfunction

    // Raw-sum expectation converted to what the build emits
    function automatic int exp_of(input int raw);
`ifdef SC_AVG_EN
        return raw >>> 2;
`else
        return raw;
`endif
    endfunction

    // Sequence word j: lane0 = 2048+2j, others mid-scale -> raw sum 4j
    function automatic logic [(N+1)*LANES-1:0] seq_word(input int j);
        return pack(2048 + 2*j, 2048, 2048, 2048);
    endfunction

    task automatic send_one(input string tag, input logic [(N+1)*LANES-1:0] w, input int raw);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = w;
        step();
        in_valid  = 1'b0;
        chk_val({tag, "_vld_e0"}, int'(out_valid), 0);
        step();
        chk_val({tag, "_vld_e1"}, int'(out_valid), 0);
        step();
        chk_val({tag, "_vld_e2"}, int'(out_valid), 1);
        chk_val({tag, "_data"}, int'(out_data), exp_of(raw));
        chk_val({tag, "_lvl1"}, int'(level), 1);
        step();
        chk_val({tag, "_lvl0"}, int'(level), 0);
    endtask

    initial begin
        step();
        step();
        chk_val("rst_vld", int'(out_valid), 0);
        chk_val("rst_lvl", int'(level), 0);
        chk_val("rst_ovf", int'(overflow), 0);
        chk_val("rst_data", int'(out_data), 0);
        reset_n = 1'b1;
        step();

        send_one("mid", pack(2048, 2048, 2048, 2048), 0);
        send_one("full", pack(4096, 4096, 4096, 4096), 16384);
        send_one("zero", pack(0, 0, 0, 0), -16384);
        send_one("clamp", pack(5000, 0, 3072, 1024), 0);
        send_one("plus2", pack(2049, 2048, 2048, 2048), 2);
        send_one("minus2", pack(2047, 2048, 2048, 2048), -2);

        // Back-to-back stream with the consumer always ready
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            if (i <= 8) begin
                in_valid = 1'b1;
                in_data  = seq_word(i);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 3) begin
                chk_val($sformatf("strm_lvl%0d", i), int'(level), 1);
                chk_val($sformatf("strm_data%0d", i), int'(out_data), exp_of(4*(i-2)));
            end
        end
        in_valid = 1'b0;
        step();
        chk_val("strm_drain", int'(level), 0);

        // Full FIFO accepts a write when a pop happens on the same edge
        out_ready = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            in_valid = 1'b1;
            in_data  = seq_word(j);
            step();
        end
        in_valid = 1'b0;
        step();
        chk_val("fpp_lvl_full", int'(level), 4);
        out_ready = 1'b1;
        step();
        chk_val("fpp_lvl_hold", int'(level), 4);
        chk_val("fpp_ovf", int'(overflow), 0);
        chk_val("fpp_head2", int'(out_data), exp_of(8));
        for (int j = 3; j <= 5; j++) begin
            step();
            chk_val($sformatf("fpp_head%0d", j), int'(out_data), exp_of(4*j));
        end
        step();
        chk_val("fpp_empty", int'(level), 0);

        // Fill and overflow: fifth word is dropped
        out_ready = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            in_valid = 1'b1;
            in_data  = seq_word(j);
            step();
        end
        in_valid = 1'b0;
        step();
        chk_val("ovf_lvl4", int'(level), 4);
        chk_val("ovf_not_yet", int'(overflow), 0);
        step();
        chk_val("ovf_lvl_hold", int'(level), 4);
        chk_val("ovf_set", int'(overflow), 1);
        out_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            chk_val($sformatf("ovf_vld%0d", j), int'(out_valid), 1);
            chk_val($sformatf("ovf_pop%0d", j), int'(out_data), exp_of(4*j));
            step();
        end
        chk_val("ovf_drained", int'(level), 0);
        for (int k = 0; k < 3; k++) begin
            chk_val($sformatf("ovf_no5th%0d", k), int'(out_valid), 0);
            step();
        end
        chk_val("ovf_sticky", int'(overflow), 1);

        // Reset with 2 words in the pipeline and 3 in the FIFO
        out_ready = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            in_valid = 1'b1;
            in_data  = seq_word(j);
            step();
        end
        in_valid = 1'b0;
        chk_val("mrst_pre_lvl", int'(level), 3);
        reset_n = 1'b0;
        #1;
        chk_val("mrst_vld", int'(out_valid), 0);
        chk_val("mrst_lvl", int'(level), 0);
        chk_val("mrst_ovf", int'(overflow), 0);
        chk_val("mrst_data", int'(out_data), 0);
        step();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_val($sformatf("mrst_quiet_vld%0d", k), int'(out_valid), 0);
            chk_val($sformatf("mrst_quiet_lvl%0d", k), int'(level), 0);
        end
        send_one("post_rst", pack(4096, 4096, 0, 4096), 8192);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
